sc_norm: RTL and testbench

Parametrised, pipelined block-floating-point normaliser for the IFFT output path. Takes complex samples framed into FRAME_LEN-sample symbols and a per-symbol block exponent. Applies the net scaling 2^(-exp) / 2^BASE_SHIFT, with optional rounding and mandatory saturation, and emits OUT_W-bit samples under valid/ready flow control. Sits between the IFFT core and the cyclic-prefix inserter, replacing the combinational fixed-range scaler.

---
 rtl/sc_norm.sv | 223 ++++++++++++++++++++++
 tb/tb_sc_norm.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_norm.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sc_norm -- pipelined block-floating-point normaliser for the IFFT output path
//
// Scales complex samples by 2^(-exp) / 2^BASE_SHIFT, where exp is a per-symbol
// block exponent latched on the sop beat. The result is saturated to OUT_W bits.
// The block has two pipeline stages under valid/ready flow control:
//   stage 1 : shift (and optional rounding), frame sop/eop tagging
//   stage 2 : saturation, output registers
//
// Compile-time option:
//   SC_NORM_ROUND_EN  defined   -> right shifts round half-up
//                     undefined -> right shifts truncate toward -inf
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake (in_ready = ~out_valid | out_ready)
//   in_sop               first sample of a symbol
//   in_real/in_imag      IN_W-bit signed input components
//   in_exp               EXP_W-bit signed block exponent (sampled on sop)
//   out_valid/out_ready  output handshake
//   out_sop/out_eop      first/last sample of an output symbol
//   out_real/out_imag    OUT_W-bit signed scaled components
//   out_sat              either component of this beat saturated
//   exp_err              sticky: a sop carried an out-of-range exponent
//   frame_err            sticky: framing violation
//   clr_err              synchronous clear of both sticky flags
// -----------------------------------------------------------------------------
module sc_norm #(
    parameter int IN_W       = 16,
    parameter int OUT_W      = 18,
    parameter int EXP_W      = 6,
    parameter int BASE_SHIFT = 6,
    parameter int EXP_MIN    = -8,
    parameter int EXP_MAX    = -4,
    parameter int FRAME_LEN  = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sop,
    input  logic [IN_W-1:0]  in_real,
    input  logic [IN_W-1:0]  in_imag,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sop,
    output logic             out_eop,
    output logic [OUT_W-1:0] out_real,
    output logic [OUT_W-1:0] out_imag,
    output logic             out_sat,
    output logic             exp_err,
    output logic             frame_err,
    input  logic             clr_err
);

    // Largest left shift the legal exponent range can ask for.
    localparam int L_RAW = -EXP_MIN - BASE_SHIFT;
    localparam int L_MAX = (L_RAW > 0) ? L_RAW : 0;
    // One guard bit for the sign, one for the rounding increment; never
    // narrower than the output plus a sign bit so the clamp bounds fit.
    localparam int MID_A = IN_W + L_MAX + 2;
    localparam int MID_W = (MID_A > OUT_W + 1) ? MID_A : OUT_W + 1;
    localparam int CNT_W = $clog2(FRAME_LEN);

    localparam logic signed [MID_W-1:0] SAT_HI  = {{(MID_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [MID_W-1:0] SAT_LO  = ~SAT_HI;
    localparam logic        [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic        [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic signed [MID_W-1:0] ONE     = {{(MID_W-1){1'b0}}, 1'b1};

    typedef enum logic {S_IDLE, S_RUN} state_t;

    // Sign-extend, then shift left (L >= 0) or arithmetic-shift right (L < 0).
    function automatic logic signed [MID_W-1:0] f_scale(input logic signed [IN_W-1:0] din,
                                                        input int shift);
        logic signed [MID_W-1:0] v;
        v = {{(MID_W-IN_W){din[IN_W-1]}}, din};
        if (shift >= 0) begin
            f_scale = v <<< shift;
        end else begin
`ifdef SC_NORM_ROUND_EN
            v = v + (ONE <<< (-shift - 1));
`endif
            f_scale = v >>> (-shift);
        end
    endfunction

    // Returns {saturated, clamped value}.
    function automatic logic [OUT_W:0] f_sat(input logic signed [MID_W-1:0] v);
        if (v > SAT_HI)      f_sat = {1'b1, OUT_MAX};
        else if (v < SAT_LO) f_sat = {1'b1, OUT_MIN};
        else                 f_sat = {1'b0, v[OUT_W-1:0]};
    endfunction

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic signed [EXP_W-1:0] r_exp;

    logic                    r_s1_valid, r_s1_sop, r_s1_eop;
    logic signed [MID_W-1:0] r_s1_re, r_s1_im;

    logic                    r_out_valid, r_out_sop, r_out_eop, r_out_sat;
    logic [OUT_W-1:0]        r_out_re, r_out_im;
    logic                    r_exp_err, r_frame_err;

    logic                    w_en, w_acc, w_keep, w_eop, w_frame_viol, w_exp_oor;
    int                      w_exp_in, w_exp_cl, w_shift;
    logic signed [EXP_W-1:0] w_exp_clamp, w_exp_use;
    logic signed [MID_W-1:0] w_re, w_im;
    logic                    w_sat_re, w_sat_im;
    logic [OUT_W-1:0]        w_q_re, w_q_im;

    // The whole pipeline stalls together when the output is held.
    assign w_en     = ~r_out_valid | out_ready;
    assign w_acc    = in_valid & w_en;
    assign in_ready = w_en;

    // NOTE: every signal driven here gets a value on every path so no latch is inferred.
    always_comb begin
        w_exp_in     = int'($signed(in_exp));
        w_exp_oor    = (w_exp_in < EXP_MIN) || (w_exp_in > EXP_MAX);
        w_exp_cl     = (w_exp_in < EXP_MIN) ? EXP_MIN :
                       (w_exp_in > EXP_MAX) ? EXP_MAX : w_exp_in;
        w_exp_clamp  = EXP_W'(w_exp_cl);
        // The sop beat itself is scaled with its own (clamped) exponent.
        w_exp_use    = in_sop ? w_exp_clamp : r_exp;
        w_shift      = -int'(w_exp_use) - BASE_SHIFT;
        w_re         = f_scale($signed(in_real), w_shift);
        w_im         = f_scale($signed(in_imag), w_shift);
        // Non-sop beats outside a symbol are dropped.
        w_keep       = w_acc & (in_sop | (r_state == S_RUN));
        w_eop        = w_acc & ~in_sop & (r_state == S_RUN) &
                       (r_cnt == CNT_W'(FRAME_LEN - 1));
        w_frame_viol = w_acc & (in_sop ? (r_state == S_RUN) : (r_state == S_IDLE));
        {w_sat_re, w_q_re} = f_sat(r_s1_re);
        {w_sat_im, w_q_im} = f_sat(r_s1_im);
    end

    // Frame FSM: tracks symbol position and holds the block exponent.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_exp   <= EXP_W'(EXP_MAX);
        end else if (w_acc) begin
            if (in_sop) begin
                r_exp   <= w_exp_clamp;
                r_cnt   <= CNT_W'(1);
                r_state <= S_RUN;
            end else if (r_state == S_RUN) begin
                if (w_eop) begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Stage 1: shifted values and frame tags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sop   <= 1'b0;
            r_s1_eop   <= 1'b0;
            r_s1_re    <= '0;
            r_s1_im    <= '0;
        end else if (w_en) begin
            r_s1_valid <= w_keep;
            r_s1_sop   <= w_keep & in_sop;
            r_s1_eop   <= w_eop;
            r_s1_re    <= w_re;
            r_s1_im    <= w_im;
        end
    end

    // Stage 2: saturation into the output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_out_re    <= '0;
            r_out_im    <= '0;
            r_out_sat   <= 1'b0;
        end else if (w_en) begin
            r_out_valid <= r_s1_valid;
            r_out_sop   <= r_s1_sop;
            r_out_eop   <= r_s1_eop;
            r_out_re    <= w_q_re;
            r_out_im    <= w_q_im;
            r_out_sat   <= r_s1_valid & (w_sat_re | w_sat_im);
        end
    end

    // Sticky error flags; a clear wins over a same-cycle set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exp_err   <= 1'b0;
            r_frame_err <= 1'b0;
        end else if (clr_err) begin
            r_exp_err   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_acc & in_sop & w_exp_oor) r_exp_err <= 1'b1;
            if (w_frame_viol)               r_frame_err <= 1'b1;
        end
    end

    assign out_valid = r_out_valid;
    assign out_sop   = r_out_sop;
    assign out_eop   = r_out_eop;
    assign out_real  = r_out_re;
    assign out_imag  = r_out_im;
    assign out_sat   = r_out_sat;
    assign exp_err   = r_exp_err;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_sc_norm.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_sc_norm -- self-checking bench for sc_norm
//
// A behavioural model computes the scaled value with plain integer arithmetic
// (multiply / floor-divide), applies the frame rules per accepted beat, and
// tracks the two-cycle, stall-together pipeline timing. A compare process
// checks the DUT against it on every falling edge. Directed sequences add
// literal expectations; a second instance with EXP_MIN=-10 covers saturation.
// -----------------------------------------------------------------------------
module tb_sc_norm;

    localparam int IN_W       = 16;
    localparam int OUT_W      = 18;
    localparam int EXP_W      = 6;
    localparam int BASE_SHIFT = 6;
    localparam int EXP_MIN    = -8;
    localparam int EXP_MAX    = -4;
    localparam int FRAME_LEN  = 64;
    localparam int OMAX  = (1 << (OUT_W - 1)) - 1;
    localparam int OMIN  = -(1 << (OUT_W - 1));
    localparam int OMASK = (1 << OUT_W) - 1;

    logic             clk, rst_n;
    logic             in_valid, in_ready, in_sop;
    logic [IN_W-1:0]  in_real, in_imag;
    logic [EXP_W-1:0] in_exp;
    logic             out_valid, out_ready, out_sop, out_eop, out_sat;
    logic [OUT_W-1:0] out_real, out_imag;
    logic             exp_err, frame_err, clr_err;

    // Second instance with a wider exponent range.
    logic             b_in_valid, b_in_ready, b_in_sop, b_out_ready, b_clr_err;
    logic [IN_W-1:0]  b_in_real, b_in_imag;
    logic [EXP_W-1:0] b_in_exp;
    logic             b_out_valid, b_out_sop, b_out_eop, b_out_sat, b_exp_err, b_frame_err;
    logic [OUT_W-1:0] b_out_real, b_out_imag;

    int n_checks = 0;
    int n_fail   = 0;

    sc_norm u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop),
        .in_real(in_real), .in_imag(in_imag), .in_exp(in_exp),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sop(out_sop), .out_eop(out_eop),
        .out_real(out_real), .out_imag(out_imag), .out_sat(out_sat),
        .exp_err(exp_err), .frame_err(frame_err), .clr_err(clr_err)
    );

    sc_norm #(.EXP_MIN(-10)) u_dut_wide (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sop(b_in_sop),
        .in_real(b_in_real), .in_imag(b_in_imag), .in_exp(b_in_exp),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_sop(b_out_sop), .out_eop(b_out_eop),
        .out_real(b_out_real), .out_imag(b_out_imag), .out_sat(b_out_sat),
        .exp_err(b_exp_err), .frame_err(b_frame_err), .clr_err(b_clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit v;
        bit sop;
        bit eop;
        bit sat;
        int re;
        int im;
    } beat_t;

    // value = din * 2^(-e) / 2^BASE_SHIFT, floored (or rounded half-up).
    function automatic int scale_m(input int din, input int e);
        int     l;
        longint num, d, q;
        l = -e - BASE_SHIFT;
        if (l >= 0) return din * (1 << l);
        d   = longint'(1) << (-l);
        num = din;
`ifdef SC_NORM_ROUND_EN
        num = num + d / 2;
`endif
        q = num / d;
        if ((num % d != 0) && (num < 0)) q = q - 1;
        return int'(q);
    endfunction

    function automatic beat_t mk_beat(input bit sop, input bit eop, input int dre,
                                      input int dim, input int e);
        beat_t b;
        int    vr, vi;
        vr = scale_m(dre, e);
        vi = scale_m(dim, e);
        b.v   = 1'b1;
        b.sop = sop;
        b.eop = eop;
        b.sat = (vr > OMAX) || (vr < OMIN) || (vi > OMAX) || (vi < OMIN);
        b.re  = (vr > OMAX) ? OMAX : (vr < OMIN) ? OMIN : vr;
        b.im  = (vi > OMAX) ? OMAX : (vi < OMIN) ? OMIN : vi;
        return b;
    endfunction

    function automatic beat_t empty_beat();
        beat_t b;
        b.v = 1'b0; b.sop = 1'b0; b.eop = 1'b0; b.sat = 1'b0; b.re = 0; b.im = 0;
        return b;
    endfunction

    beat_t m_s1, m_out;
    bit    m_in_frame, m_exp_err, m_frame_err;
    int    m_idx, m_exp;

    always @(posedge clk or negedge rst_n) begin : model
        bit    en, set_e, set_f;
        beat_t nb;
        int    e;
        if (!rst_n) begin
            m_s1 = empty_beat(); m_out = empty_beat();
            m_in_frame = 0; m_idx = 0; m_exp = EXP_MAX;
            m_exp_err = 0; m_frame_err = 0;
        end else begin
            en = !m_out.v || (out_ready === 1'b1);
            nb = empty_beat();
            set_e = 0; set_f = 0;
            if (en && in_valid) begin
                if (in_sop) begin
                    e = int'($signed(in_exp));
                    if (e < EXP_MIN || e > EXP_MAX) set_e = 1;
                    m_exp = (e < EXP_MIN) ? EXP_MIN : (e > EXP_MAX) ? EXP_MAX : e;
                    if (m_in_frame) set_f = 1;
                    m_in_frame = 1; m_idx = 0;
                    nb = mk_beat(1, 0, int'($signed(in_real)), int'($signed(in_imag)), m_exp);
                end else if (m_in_frame) begin
                    m_idx++;
                    nb = mk_beat(0, m_idx == FRAME_LEN - 1, int'($signed(in_real)),
                                 int'($signed(in_imag)), m_exp);
                    if (m_idx == FRAME_LEN - 1) m_in_frame = 0;
                end else begin
                    set_f = 1;
                end
            end
            if (en) begin
                m_out = m_s1;
                m_s1  = nb;
            end
            if (clr_err) begin
                m_exp_err = 0; m_frame_err = 0;
            end else begin
                m_exp_err   = m_exp_err | set_e;
                m_frame_err = m_frame_err | set_f;
            end
        end
    end

    // Compare process, away from the active edge.
    always @(negedge clk) begin
        check("in_ready",  64'(in_ready),  64'(!m_out.v || out_ready));
        check("out_valid", 64'(out_valid), 64'(m_out.v));
        check("exp_err",   64'(exp_err),   64'(m_exp_err));
        check("frame_err", 64'(frame_err), 64'(m_frame_err));
        if (m_out.v) begin
            check("out_sop",  64'(out_sop),  64'(m_out.sop));
            check("out_eop",  64'(out_eop),  64'(m_out.eop));
            check("out_sat",  64'(out_sat),  64'(m_out.sat));
            check("out_real", 64'(out_real), 64'(m_out.re & OMASK));
            check("out_imag", 64'(out_imag), 64'(m_out.im & OMASK));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input bit sop, input logic [IN_W-1:0] re,
                         input logic [IN_W-1:0] im, input logic [EXP_W-1:0] e);
        @(posedge clk);
        #1;
        in_valid = v; in_sop = sop; in_real = re; in_imag = im; in_exp = e;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int sent, cyc;
        rst_n = 1'b0; in_valid = 0; in_sop = 0; in_real = '0; in_imag = '0;
        in_exp = '0; out_ready = 1'b0; clr_err = 1'b0;
        b_in_valid = 0; b_in_sop = 0; b_in_real = '0; b_in_imag = '0; b_in_exp = '0;
        b_out_ready = 1'b1; b_clr_err = 1'b0;

        // Pin the model against hand-computed values.
        check("model_m8_real", 64'(scale_m(16'sh1234, -8)), 64'(18640));
        check("model_m8_imag", 64'(scale_m(32767, -8)),     64'(131068));
`ifdef SC_NORM_ROUND_EN
        check("model_m4_pos", 64'(scale_m(6, -4)),  64'(2));
        check("model_m4_neg", 64'(scale_m(-6, -4)), 64'(-1));
`else
        check("model_m4_pos", 64'(scale_m(6, -4)),  64'(1));
        check("model_m4_neg", 64'(scale_m(-6, -4)), 64'(-2));
`endif

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready",  64'(in_ready),  64'(1));
        check("rst_out_real",  64'(out_real),  64'(0));
        check("rst_out_sat",   64'(out_sat),   64'(0));
        check("rst_exp_err",   64'(exp_err),   64'(0));
        check("rst_frame_err", 64'(frame_err), 64'(0));

        // Wide instance: exp=-10 saturates both components.
        @(posedge clk); #1;
        b_in_valid = 1; b_in_sop = 1; b_in_real = 16'h7FFF; b_in_imag = 16'h8000;
        b_in_exp = 6'b110110;
        @(posedge clk); #1 b_in_valid = 0; b_in_sop = 0;
        @(posedge clk); #1;
        check("wide_valid", 64'(b_out_valid), 64'(1));
        check("wide_sop",   64'(b_out_sop),   64'(1));
        check("wide_eop",   64'(b_out_eop),   64'(0));
        check("wide_real",  64'(b_out_real),  64'(18'h1FFFF));
        check("wide_imag",  64'(b_out_imag),  64'(18'h20000));
        check("wide_sat",   64'(b_out_sat),   64'(1));
        check("wide_errs",  64'({b_exp_err, b_frame_err}), 64'(0));
        check("wide_ready", 64'(b_in_ready),  64'(1));

        // Full symbol at exp=-8, latency 2, eop on beat 63.
        out_ready = 1'b1;
        for (int i = 0; i < FRAME_LEN + 2; i++) begin
            drive(i < FRAME_LEN, i == 0, 16'h1234, 16'h7FFF, 6'b111000);
            if (i == 2) begin
                check("t1_lat_valid", 64'(out_valid), 64'(1));
                check("t1_sop",       64'(out_sop),   64'(1));
                check("t1_real",      64'(out_real),  64'(18'h048D0));
                check("t1_imag",      64'(out_imag),  64'(18'h1FFFC));
                check("t1_sat",       64'(out_sat),   64'(0));
            end
            if (i == FRAME_LEN + 1) begin
                check("t1_eop", 64'(out_eop), 64'(1));
            end
        end

        // exp=-4 right shift: rounding vs truncation.
        drive(1, 1, 16'd6, 16'hFFFA, 6'b111100);
        drive(0, 0, '0, '0, '0);
        drive(0, 0, '0, '0, '0);
`ifdef SC_NORM_ROUND_EN
        check("t2_real", 64'(out_real), 64'(18'h00002));
        check("t2_imag", 64'(out_imag), 64'(18'h3FFFF));
`else
        check("t2_real", 64'(out_real), 64'(18'h00001));
        check("t2_imag", 64'(out_imag), 64'(18'h3FFFE));
`endif

        // exp=-12 is out of range: flagged, scaled as -8; then clear.
        for (int i = 0; i < FRAME_LEN; i++) begin
            drive(1, i == 0, 16'h1234, 16'h0100, (i == 0) ? 6'b110100 : 6'($urandom));
            if (i == 1) check("t3_exp_err", 64'(exp_err), 64'(1));
            if (i == 2) check("t3_real",    64'(out_real), 64'(18'h048D0));
            if (i == 5) clr_err = 1'b1;
            if (i == 6) begin
                clr_err = 1'b0;
                check("t3_clr_exp",   64'(exp_err),   64'(0));
                check("t3_clr_frame", 64'(frame_err), 64'(0));
            end
        end

        // Early sop at beat 10 restarts the count.
        for (int i = 0; i < FRAME_LEN + 10; i++) begin
            drive(1, (i == 0) || (i == 10), 16'(i * 37), 16'(-i * 11), 6'b111010);
            if (i == 11) check("t4_frame_err", 64'(frame_err), 64'(1));
        end
        drive(0, 0, '0, '0, '0);
        clr_err = 1'b1;
        drive(0, 0, '0, '0, '0);
        clr_err = 1'b0;
        check("t4_clr", 64'(frame_err), 64'(0));
        // Stray non-sop beat while idle: flagged and dropped.
        drive(1, 0, 16'h5555, 16'h5555, 6'b111010);
        drive(0, 0, '0, '0, '0);
        check("t4_idle_err", 64'(frame_err), 64'(1));
        drive(0, 0, '0, '0, '0);
        check("t4_idle_drop", 64'(out_valid), 64'(0));

        // Randomized traffic with backpressure over three symbols.
        sent = 0; cyc = 0;
        while (sent < 3 * FRAME_LEN && cyc < 4000) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 2) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sop    = (sent % FRAME_LEN == 0);
            in_real   = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
            in_imag   = ($urandom_range(0, 7) == 0) ? 16'h7FFF : 16'($urandom);
            in_exp    = EXP_W'(-3 - int'($urandom_range(0, 6)));
            clr_err   = ($urandom_range(0, 40) == 0);
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            cyc++;
        end
        check("rand_beats_sent", 64'(sent), 64'(3 * FRAME_LEN));
        clr_err = 1'b0;
        out_ready = 1'b1;
        repeat (3) drive(0, 0, '0, '0, '0);

        // Reset mid-frame.
        for (int i = 0; i < 6; i++) drive(1, i == 0, 16'(i), 16'(i), 6'b111010);
        @(posedge clk); #1;
        in_valid = 0;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 64'(out_valid), 64'(0));
        check("rst_mid_ready", 64'(in_ready),  64'(1));
        @(posedge clk); #1 rst_n = 1'b1;
        drive(1, 0, 16'h0011, 16'h0022, 6'b111010);
        drive(0, 0, '0, '0, '0);
        check("rst_idle_err", 64'(frame_err), 64'(1));
        drive(0, 0, '0, '0, '0);
        check("rst_idle_drop", 64'(out_valid), 64'(0));
        repeat (2) drive(0, 0, '0, '0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
